// File: rtl/seq_mult_8.sv
// Unsigned 8x8 shift-and-add multiplier: one partial-product add per clock
// through a ripple-carry adder, 16-bit product under a start/busy/done handshake.

module full_adder_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [8:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[8];
endmodule

// state | meaning
// IDLE  | waiting for start; busy=0, done=0
// CALC  | one add/shift iteration per edge; busy=1
// DONE  | product valid for one cycle; done=1, start may chain a new op
module seq_mult_8 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  // Encoding chosen so busy and done are single state flops.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   add_sum;
  logic               add_c;
  logic [2*WIDTH-1:0] acc_next;

  assign addend = acc_lo[0] ? mcand : '0;

  full_adder_8 u_add (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_c)
  );

  // 17-bit {carry,sum,lo} shifted right by one keeps the carry in the accumulator.
  assign acc_next = {add_c, add_sum, acc_lo[WIDTH-1:1]};

  assign busy = state[0];
  assign done = state[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            cnt    <= '0;
            state  <= CALC;
          end else begin
            state  <= IDLE;
          end
        end
        CALC: begin
          {acc_hi, acc_lo} <= acc_next;
          cnt              <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            product <= acc_next;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mult_8.sv
// Self-checking bench for seq_mult_8: vector table, scoreboard queue, corner sequences.

module tb_seq_mult_8;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] sb_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  seq_mult_8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Product checker: every done pulse pops the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        check("sb_product", int'(product), int'(sb_q.pop_front()));
      end
    end
  end

  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input bit push);
    a = av;
    b = bv;
    start = 1'b1;
    if (push) sb_q.push_back(16'(av) * 16'(bv));
    tick();
    start = 1'b0;
  endtask

  // Called just after the accepting edge; returns just after the done edge.
  task automatic wait_done(input bit hold_start);
    bit ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!(busy === 1'b1 && done === 1'b0)) ok = 1'b0;
      if (hold_start) begin
        start = 1'b1;
        a = 8'($urandom);
        b = 8'($urandom);
      end
      if (i == 7) start = 1'b0;
      tick();
    end
    check("busy_window", int'(ok), 1);
    check("done_pulse", int'({busy, done}), 1);
  endtask

  initial begin
    vecs[0] = '{8'd13,  8'd11,  16'h008F};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'd0,   8'd200, 16'h0000};
    vecs[3] = '{8'd200, 8'd0,   16'h0000};
    vecs[4] = '{8'd1,   8'd1,   16'h0001};
    vecs[5] = '{8'd255, 8'd1,   16'h00FF};
    vecs[6] = '{8'd128, 8'd2,   16'h0100};
    vecs[7] = '{8'd7,   8'd9,   16'h003F};

    #12;
    check("reset_outputs", int'({busy, done, product}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", int'({busy, done}), 0);

    // Table vectors, each from IDLE, with product hold check afterwards.
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, 1'b1);
      wait_done(1'b0);
      check($sformatf("vec%0d_product", i), int'(product), int'(vecs[i].exp));
      tick();
      tick();
      check($sformatf("vec%0d_hold", i), int'({busy, done, product}), int'(vecs[i].exp));
    end

    // start held high and operands toggled during CALC.
    start_op(8'd13, 8'd11, 1'b1);
    wait_done(1'b1);
    check("held_start_product", int'(product), 143);
    tick();
    check("held_start_to_idle", int'({busy, done}), 0);

    // Back-to-back: new start in the DONE cycle.
    start_op(8'd13, 8'd11, 1'b1);
    wait_done(1'b0);
    check("b2b_first", int'(product), 143);
    start_op(8'd7, 8'd9, 1'b1);
    check("b2b_no_idle", int'({busy, done}), 2);
    for (int i = 0; i < 7; i++) tick();
    tick();
    check("b2b_done", int'({busy, done}), 1);
    check("b2b_second", int'(product), 63);
    tick();

    // Async reset at iteration 4 of 200*100.
    start_op(8'd200, 8'd100, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("pre_reset_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", int'({busy, done, product}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", int'({busy, done, product}), 0);
    start_op(8'd3, 8'd5, 1'b1);
    wait_done(1'b0);
    check("post_reset_3x5", int'(product), 15);
    tick();

    // Random operands; roughly half chained back-to-back.
    for (int i = 0; i < 2000; i++) begin
      start_op(8'($urandom), 8'($urandom), 1'b1);
      wait_done(1'b0);
      if ($urandom_range(0, 1) == 0) tick();
    end
    tick();
    tick();

    check("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
